// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes big-endian
// 32-bit words to instruction memory and releases the core once the image is verified.
module prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          csum_q, csum_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         shift_q, shift_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [DATA_W-1:0]   im_wdata_q, im_wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;
    logic [CNT_W-1:0]    len_next;

    // Handshake: a byte moves on a rising edge where in_valid and in_ready are both high.
    // in_ready depends on state only; the sender may hold or drop in_valid freely.
    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
    assign busy     = in_ready;
    assign xfer     = in_valid & in_ready;
    assign len_next = {1'b0, len_q[15:8], in_data};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        words_d    = words_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    csum_d     = 8'd0;
                    words_d    = '0;
                    byte_idx_d = 2'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    hold_d     = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    csum_d      = csum_q ^ in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d      = {len_q[15:8], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = 2'd0;
                    if (len_next > MAX_WORDS) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len_next == '0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d     = csum_q ^ in_data;
                    shift_d    = {shift_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Word completes: write lands next cycle at the pre-increment count.
                    if (byte_idx_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = words_q[ADDR_W-1:0];
                        im_wdata_d = {shift_q, in_data};
                        words_d    = words_q + 1'b1;
                        if ((CNT_W'(words_q) + CNT_W'(1)) == {1'b0, len_q})
                            state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            csum_q     <= 8'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
            words_q    <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            words_q    <= words_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign core_hold    = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, gaps, bad checksum, oversize, zero and max length,
// mid-load reset. Memory writes are checked against an expected queue.
module tb_prog_loader;

    localparam int AW = 10;
    localparam int WW = AW + 32;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic [WW-1:0] exp_q[$];

    prog_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin : sb
        logic [WW-1:0] got;
        logic [WW-1:0] exp;
        if (rst && im_we) begin
            we_count++;
            got = {im_addr, im_wdata};
            exp = 'x;
            if (exp_q.size() != 0) exp = exp_q.pop_front();
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL im_write got=%0h exp=%0h", got, exp);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout got=%0d exp=<20", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_bytes(input bq_t bs, input int gap);
        foreach (bs[i]) send_byte(bs[i], gap);
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin : stim
        int we0;
        logic [2:0] st0;

        // reset state
        #12;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_hold", 64'(core_hold), 64'd1);
        check("rst_flags", 64'({busy, done, err, im_we, in_ready}), 64'd0);
        check("rst_addr_data", 64'({im_addr, im_wdata}), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk); rst = 1'b1;

        // two words back-to-back
        push_exp(10'd0, 32'h0000_0013);
        push_exp(10'd1, 32'hDEAD_BEEF);
        we0 = we_count;
        pulse_start();
        check("s1_busy", 64'(busy), 64'd1);
        send_bytes('{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33}, 0);
        check("s1_done_err_hold", 64'({done, err, core_hold}), 64'b100);
        check("s1_words", 64'(words_loaded), 64'd2);
        check("s1_we_count", 64'(we_count - we0), 64'd2);
        check("s1_exp_empty", 64'(exp_q.size()), 64'd0);
        check("s1_ready", 64'(in_ready), 64'd0);

        // one word with gaps, restarted from DONE
        push_exp(10'd0, 32'h1234_5678);
        we0 = we_count;
        pulse_start();
        check("s2_hold_restart", 64'(core_hold), 64'd1);
        check("s2_done_clr", 64'(done), 64'd0);
        send_bytes('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 3);
        check("s2_done", 64'({done, err, core_hold}), 64'b100);
        check("s2_we_count", 64'(we_count - we0), 64'd1);
        check("s2_words", 64'(words_loaded), 64'd1);

        // bad checksum
        push_exp(10'd0, 32'h1234_5678);
        we0 = we_count;
        pulse_start();
        send_bytes('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A}, 0);
        check("s3_err", 64'({done, err, core_hold, in_ready}), 64'b0110);
        check("s3_we_count", 64'(we_count - we0), 64'd1);
        // bytes offered while not ready are ignored
        st0 = dbg_state;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("s3_ignore_state", 64'(dbg_state), 64'(st0));
        check("s3_ignore_words", 64'(words_loaded), 64'd1);
        check("s3_ignore_we", 64'(we_count - we0), 64'd1);

        // oversize length 0x0401 > 1024
        we0 = we_count;
        pulse_start();
        send_bytes('{8'h04, 8'h01}, 0);
        check("s4_state", 64'(dbg_state), 64'd6);
        check("s4_err", 64'({err, done, in_ready, core_hold}), 64'b1001);
        repeat (3) @(posedge clk);
        #1;
        check("s4_no_we", 64'(we_count - we0), 64'd0);

        // zero length
        we0 = we_count;
        pulse_start();
        send_bytes('{8'h00, 8'h00, 8'h00}, 0);
        check("s5_done", 64'({done, err, core_hold}), 64'b100);
        check("s5_words", 64'(words_loaded), 64'd0);
        check("s5_no_we", 64'(we_count - we0), 64'd0);

        // start while busy is ignored, then asynchronous reset mid-load
        push_exp(10'd0, 32'h0000_0013);
        pulse_start();
        send_bytes('{8'h00, 8'h02, 8'h00, 8'h00}, 0);
        pulse_start();
        check("s6_start_busy_state", 64'(dbg_state), 64'd3);
        send_bytes('{8'h00, 8'h13, 8'hDE, 8'hAD}, 0);
        check("s6_words_mid", 64'(words_loaded), 64'd1);
        #3 rst = 1'b0;
        #1;
        check("s6_rst_state", 64'(dbg_state), 64'd0);
        check("s6_rst_hold", 64'(core_hold), 64'd1);
        check("s6_rst_flags", 64'({busy, done, err, im_we, in_ready}), 64'd0);
        check("s6_rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk); rst = 1'b1;
        push_exp(10'd0, 32'h0000_0013);
        push_exp(10'd1, 32'hDEAD_BEEF);
        we0 = we_count;
        pulse_start();
        send_bytes('{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h33}, 0);
        check("s6_done", 64'({done, err, core_hold}), 64'b100);
        check("s6_we_count", 64'(we_count - we0), 64'd2);
        check("s6_exp_empty", 64'(exp_q.size()), 64'd0);

        // maximum length: 1024 zero words, checksum 0x04
        for (int i = 0; i < 1024; i++) push_exp(AW'(i), 32'h0);
        we0 = we_count;
        pulse_start();
        send_bytes('{8'h04, 8'h00}, 0);
        for (int i = 0; i < 4096; i++) send_byte(8'h00, 0);
        check("s7_words_pre_chk", 64'(words_loaded), 64'd1024);
        check("s7_state_chk", 64'(dbg_state), 64'd4);
        send_byte(8'h04, 0);
        check("s7_done", 64'({done, err, core_hold}), 64'b100);
        check("s7_last_addr", 64'(im_addr), 64'd1023);
        check("s7_we_count", 64'(we_count - we0), 64'd1024);
        check("s7_exp_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
